// File: rtl/parity_frame_checker.sv
// ---------------------------------------------------------------------------
// parity_frame_checker
//   Serial frame receiver and checker. A frame is a start bit (0), DATA_W data
//   bits sent LSB first, one parity bit and one stop bit (1). Bits are taken
//   only on cycles with bit_valid=1; any other cycle is a stall and leaves all
//   state alone. A completed frame is reported one cycle after its stop bit
//   is accepted, and it is delivered even when it carries errors.
//
//   Optional feature: define PARITY_ERR_COUNT_EN to build the saturating
//   errored-frame counter. Without it err_count is tied to 0.
//
// Parameters
//   DATA_W      data bits per frame (1..16)
//   ODD         0 = even parity, 1 = odd parity
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   bit_in      serial line bit
//   bit_valid   qualifies bit_in; 0 = stall cycle
//   data_out    last received data word (held until the next frame)
//   data_valid  one-cycle pulse marking a completed frame
//   parity_err  parity mismatch on the completed frame (only with data_valid)
//   frame_err   stop bit was 0 on the completed frame (only with data_valid)
//   busy        FSM is not in IDLE
//   err_count   saturating count of errored frames
// ---------------------------------------------------------------------------
module parity_frame_checker #(
    parameter int DATA_W = 8,
    parameter bit ODD    = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_in,
    input  logic              bit_valid,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic              parity_err,
    output logic              frame_err,
    output logic              busy,
    output logic [7:0]        err_count
);

    localparam int               IDX_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] data_sh;
    logic              run_par;   // XOR of the data bits accepted so far
    logic              par_bad;   // parity mismatch of the current frame
    logic              stop_acc;  // stop bit accepted this cycle

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next state; nothing moves on a stall cycle
    always_comb begin
        state_nxt = state;
        stop_acc  = 1'b0;
        if (bit_valid) begin
            case (state)
                IDLE:   if (!bit_in) state_nxt = DATA;
                DATA:   if (idx == LAST_IDX) state_nxt = PARITY;
                PARITY: state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    stop_acc  = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Datapath: shift-in, running parity and frame report
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx        <= '0;
            data_sh    <= '0;
            run_par    <= 1'b0;
            par_bad    <= 1'b0;
            data_out   <= '0;
            data_valid <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Error flags are only meaningful alongside the pulse, so they
            // are forced low on every other cycle.
            data_valid <= stop_acc;
            parity_err <= stop_acc & par_bad;
            frame_err  <= stop_acc & ~bit_in;
            if (stop_acc) data_out <= data_sh;

            if (bit_valid) begin
                case (state)
                    IDLE: begin
                        if (!bit_in) begin
                            idx     <= '0;
                            run_par <= 1'b0;
                        end
                    end
                    DATA: begin
                        data_sh[idx] <= bit_in;
                        idx          <= idx + 1'b1;
                        run_par      <= run_par ^ bit_in;
                    end
                    PARITY: par_bad <= (bit_in != (run_par ^ ODD));
                    default: ;
                endcase
            end
        end
    end

    assign busy = (state != IDLE);

`ifdef PARITY_ERR_COUNT_EN
    // Counts at the same edge that raises data_valid, so err_count already
    // includes a frame while its pulse is visible. One step per frame even
    // when both error kinds are present.
    logic [7:0] err_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            err_cnt <= 8'h00;
        else if (stop_acc && (par_bad || !bit_in) && (err_cnt != 8'hFF))
            err_cnt <= err_cnt + 8'h01;
    end

    assign err_count = err_cnt;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// ---------------------------------------------------------------------------
// tb_parity_frame_checker
//   Two checkers (even and odd parity) receive the same serial stream. Each
//   issued frame pushes its hand-computed result into one queue per checker;
//   a monitor pops and compares whenever a checker raises data_valid.
// ---------------------------------------------------------------------------
module tb_parity_frame_checker;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_in;
    logic       bit_valid;

    logic [7:0] data_out0, data_out1;
    logic       dv0, dv1, pe0, pe1, fe0, fe1, busy0, busy1;
    logic [7:0] cnt0, cnt1;

    exp_t q0[$];
    exp_t q1[$];
    int   exp_cnt0 = 0;
    int   exp_cnt1 = 0;
    int   vectors  = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    parity_frame_checker #(.DATA_W(8), .ODD(1'b0)) dut_even (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out0), .data_valid(dv0), .parity_err(pe0),
        .frame_err(fe0), .busy(busy0), .err_count(cnt0)
    );

    parity_frame_checker #(.DATA_W(8), .ODD(1'b1)) dut_odd (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bit_valid),
        .data_out(data_out1), .data_valid(dv1), .parity_err(pe1),
        .frame_err(fe1), .busy(busy1), .err_count(cnt1)
    );

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present one bit for exactly one accepting edge, after 'gaps' stalls
    task automatic drive_bit(input logic b, input int gaps);
        bit_valid = 1'b0;
        repeat (gaps) @(posedge clk);
        #1;
        bit_valid = 1'b1;
        bit_in    = b;
        @(posedge clk);
        #1;
        bit_valid = 1'b0;
        bit_in    = 1'b1;
    endtask

    function automatic int sat_inc(input int c, input logic err);
`ifdef PARITY_ERR_COUNT_EN
        if (err && c < 255) return c + 1;
`endif
        return c;
    endfunction

    // pe_e / pe_o: hand-computed parity error for the even / odd checker
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop,
                              input logic pe_e, input logic pe_o, input int max_gap);
        exp_t e;
        e.d = d; e.fe = ~stop;
        e.pe = pe_e; q0.push_back(e);
        e.pe = pe_o; q1.push_back(e);
        exp_cnt0 = sat_inc(exp_cnt0, pe_e | ~stop);
        exp_cnt1 = sat_inc(exp_cnt1, pe_o | ~stop);
        drive_bit(1'b0, $urandom_range(0, max_gap));
        for (int i = 0; i < 8; i++) drive_bit(d[i], $urandom_range(0, max_gap));
        drive_bit(par, $urandom_range(0, max_gap));
        drive_bit(stop, $urandom_range(0, max_gap));
    endtask

    task automatic mon_one(input int which, input logic dv, input logic [7:0] d,
                           input logic pe, input logic fe);
        exp_t e;
        if (dv) begin
            if ((which == 0 && q0.size() == 0) || (which == 1 && q1.size() == 0)) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_pulse dut%0d: data_out 0x%0h with no frame pending", which, d);
            end else begin
                e = (which == 0) ? q0.pop_front() : q1.pop_front();
                chk($sformatf("data_out dut%0d", which), int'(d), int'(e.d));
                chk($sformatf("parity_err dut%0d", which), int'(pe), int'(e.pe));
                chk($sformatf("frame_err dut%0d", which), int'(fe), int'(e.fe));
            end
        end else if (pe || fe) begin
            miscompares++;
            $display("FAIL err_without_valid dut%0d: parity_err %0b frame_err %0b required 0", which, pe, fe);
        end
    endtask

    // Monitor
    initial begin
        forever begin
            @(negedge clk);
            if (!reset) begin
                mon_one(0, dv0, data_out0, pe0, fe0);
                mon_one(1, dv1, data_out1, pe1, fe1);
            end
        end
    end

    // Global time limit
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset     = 1'b1;
        bit_in    = 1'b1;
        bit_valid = 1'b0;
        #12;
        chk("reset data_out", int'(data_out0), 0);
        chk("reset data_valid", int'(dv0), 0);
        chk("reset parity_err", int'(pe0), 0);
        chk("reset frame_err", int'(fe0), 0);
        chk("reset busy", int'(busy0), 0);
        chk("reset err_count", int'(cnt0), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        // idle line (1s) must not start a frame
        drive_bit(1'b1, 0);
        drive_bit(1'b1, 0);
        chk("idle busy", int'(busy0), 0);

        // 0xA5 (four ones): good even parity, then bad even parity
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
`ifdef PARITY_ERR_COUNT_EN
        chk("err_count after bad A5", int'(cnt0), 1);
`else
        chk("err_count after bad A5", int'(cnt0), 0);
`endif

        // 0x07 (three ones)
        send_frame(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, 0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b0, 1'b1, 0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0, 1'b1, 0);

        // Stalls between bits, then a back-to-back frame
        send_frame(8'hA5, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        repeat (3) @(posedge clk);

        // Abort a frame with reset after 4 data bits
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b0, 0);
        drive_bit(1'b1, 0);
        drive_bit(1'b0, 0);
        chk("busy mid-frame", int'(busy0), 1);
        #3;
        reset = 1'b1;
        #1;
        chk("abort data_out", int'(data_out0), 0);
        chk("abort busy", int'(busy0), 0);
        chk("abort err_count", int'(cnt0), 0);
        exp_cnt0 = 0;
        exp_cnt1 = 0;
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(posedge clk);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b0, 1'b1, 0);
        chk("busy after stop", int'(busy0), 0);
        repeat (4) @(posedge clk);
        #1;
        chk("data_out hold", int'(data_out0), 'h5A);
        chk("data_valid after pulse", int'(dv0), 0);

        // Saturation: 260 frames with bad even parity
        for (int n = 0; n < 260; n++) send_frame(8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("err_count even", int'(cnt0), exp_cnt0);
        chk("err_count odd", int'(cnt1), exp_cnt1);
`ifdef PARITY_ERR_COUNT_EN
        chk("err_count saturated", int'(cnt0), 255);
`else
        chk("err_count disabled", int'(cnt0), 0);
`endif

        // Drain the scoreboard
        for (int t = 0; t < 50 && (q0.size() != 0 || q1.size() != 0); t++) @(posedge clk);
        vectors++;
        if (q0.size() != 0 || q1.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d/%0d frames never reported, required 0", q0.size(), q1.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
